// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the default operand width.
package serial_arith_pkg;

    // Default operand width in bits; legal range is 2..32.
    localparam int DEFAULT_WIDTH = 8;

    // Operation sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of a counter able to hold the values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow-out.
// Purely combinational; the serial datapath reuses one instance per bit-time.
module full_subtractor
    import serial_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic axb_s;

    // Difference bit and borrow generate/propagate for a single bit position.
    always_comb begin
        axb_s = a ^ b;
        diff  = axb_s ^ bin;
        bout  = (~a & b) | (~axb_s & bin);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes val1 - val2 - bin one bit per
// clock, LSB first, using a single full_subtractor. Result and borrow-out
// are published on the done pulse and held until the next accepted start.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

    logic             bit_d_s;
    logic             bit_bout_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] res_next_s;

    // Single shared bit-slice operating on the current operand LSBs.
    full_subtractor u_fs (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (br_r),
        .diff (bit_d_s),
        .bout (bit_bout_s)
    );

    // Next result word (new bit enters at the MSB) and last-bit detection.
    always_comb begin
        res_next_s = {bit_d_s, res_r[WIDTH-1:1]};
        if (cnt_r == LAST_CNT) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Sequencer: accept start, shift WIDTH bits, then publish the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            br_r    <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            diff_r  <= '0;
            bout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Operands are captured here; later input changes
                        // cannot disturb the operation in flight.
                        a_r     <= val1;
                        b_r     <= val2;
                        br_r    <= bin;
                        res_r   <= '0;
                        cnt_r   <= '0;
                        state_r <= ST_SHIFT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // start is deliberately ignored while shifting.
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    br_r  <= bit_bout_s;
                    res_r <= res_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        diff_r  <= res_next_s;
                        bout_r  <= bit_bout_s;
                    end else begin
                        state_r <= ST_SHIFT;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] val1;
    logic [W-1:0] val2;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int tests;
    int fails;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .val1  (val1),
        .val2  (val2),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] v1;
        logic [W-1:0] v2;
        logic         bi;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one subtraction from IDLE; scrambles inputs after acceptance.
    task automatic do_op(input logic [W-1:0] v1, input logic [W-1:0] v2, input logic bi,
                         input logic [W-1:0] ed, input logic eb, input string name);
        int cyc;
        @(negedge clk);
        val1 = v1; val2 = v2; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        val1 = ~v1; val2 = v2 + 8'd17; bin = ~bi;
        cyc = 1;
        check({name, " busy_c1"}, {31'd0, busy}, 32'd1);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " done_cycle"}, cyc, 32'd9);
        check({name, " diff"}, {24'd0, diff}, {24'd0, ed});
        check({name, " bout"}, {31'd0, bout}, {31'd0, eb});
        @(negedge clk);
        check({name, " done_pulse_end"}, {31'd0, done}, 32'd0);
        check({name, " diff_held"}, {24'd0, diff}, {24'd0, ed});
    endtask

    initial begin
        int cyc;
        int ndone;
        int first_done;
        int second_done;
        tests = 0; fails = 0;
        rst = 1'b1; start = 1'b0; val1 = '0; val2 = '0; bin = 1'b0;

        vecs[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
        vecs[1] = '{8'd5,   8'd9,   1'b0, 8'd252, 1'b1};
        vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
        vecs[3] = '{8'd255, 8'd255, 1'b0, 8'd0,   1'b0};
        vecs[4] = '{8'd255, 8'd254, 1'b1, 8'd0,   1'b0};
        vecs[5] = '{8'd200, 8'd56,  1'b0, 8'd144, 1'b0};
        vecs[6] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1};
        vecs[7] = '{8'd128, 8'd1,   1'b1, 8'd126, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst diff", {24'd0, diff}, 32'd0);
        check("rst bout", {31'd0, bout}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].v1, vecs[i].v2, vecs[i].bi, vecs[i].exp_diff, vecs[i].exp_bout,
                  $sformatf("vec%0d", i));
        end

        // Start during SHIFT is ignored
        @(negedge clk);
        val1 = 8'd100; val2 = 8'd37; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1; ndone = 0; first_done = 0;
        while (cyc < 14) begin
            if (cyc == 3) begin
                val1 = 8'd9; val2 = 8'd200; bin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = cyc;
                check("ign diff", {24'd0, diff}, 32'd63);
                check("ign bout", {31'd0, bout}, 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("ign ndone", ndone, 32'd1);
        check("ign done_cycle", first_done, 32'd9);

        // Reset in the middle of SHIFT aborts with no done
        @(negedge clk);
        val1 = 8'd5; val2 = 8'd9; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst busy", {31'd0, busy}, 32'd0);
        check("mid_rst done", {31'd0, done}, 32'd0);
        check("mid_rst diff", {24'd0, diff}, 32'd0);
        check("mid_rst bout", {31'd0, bout}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_rst no_done", ndone, 32'd0);
        do_op(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, "post_rst");

        // Back-to-back: start held high through DONE
        @(negedge clk);
        val1 = 8'd100; val2 = 8'd37; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        cyc = 1; first_done = 0; second_done = 0;
        while (second_done == 0 && cyc < 30) begin
            if (done) begin
                if (first_done == 0) begin
                    first_done = cyc;
                    check("b2b diff1", {24'd0, diff}, 32'd63);
                    check("b2b bout1", {31'd0, bout}, 32'd0);
                    val1 = 8'd200; val2 = 8'd56; bin = 1'b0;
                end else begin
                    second_done = cyc;
                    check("b2b diff2", {24'd0, diff}, 32'd144);
                    check("b2b bout2", {31'd0, bout}, 32'd0);
                    start = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("b2b first_cycle", first_done, 32'd9);
        check("b2b spacing", second_done - first_done, W + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL be declared with default 8: operand width in bits, legal range 2..32.
REQ-002 Port clk SHALL be input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start SHALL be input, 1 bit: request to begin a subtraction, sampled on rising clk.
REQ-005 Port val1 SHALL be input, WIDTH bits: minuend, captured when start is accepted.
REQ-006 Port val2 SHALL be input, WIDTH bits: subtrahend, captured when start is accepted.
REQ-007 Port bin SHALL be input, 1 bit: borrow-in, captured when start is accepted.
REQ-008 Port busy SHALL be output, 1 bit: high while bits are being processed.
REQ-009 Port done SHALL be output, 1 bit: single-cycle pulse marking a valid result.
REQ-010 Port diff SHALL be output, WIDTH bits: result val1 - val2 - bin, modulo 2^WIDTH.
REQ-011 Port bout SHALL be output, 1 bit: borrow-out, high when val1 < val2 + bin (unsigned).

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 start SHALL be accepted in IDLE or DONE only; in SHIFT it SHALL be ignored.
REQ-014 On acceptance the block SHALL load val1 and val2 into shift registers, load bin into the borrow flop, clear the bit counter, and go to SHIFT.
REQ-015 In each SHIFT cycle the block SHALL process the LSBs of both operands: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
REQ-016 Each SHIFT cycle SHALL shift the operand registers right by one and shift d into the MSB of the result register.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, counted by a counter of width clog2(WIDTH+1); it then goes to DONE.
REQ-018 done SHALL be high for exactly one cycle in DONE, WIDTH+1 cycles after the clock edge that accepted start.
REQ-019 diff and bout SHALL be valid from the done cycle and held unchanged until the next accepted start.
REQ-020 DONE SHALL go to IDLE when start is low and to SHIFT (back-to-back) when start is high.
REQ-021 busy SHALL equal (state == SHIFT).
REQ-022 Operands SHALL be unsigned; overflow SHALL wrap modulo 2^WIDTH, and bout SHALL be the sole underflow indicator.
REQ-023 Changes on val1, val2 and bin after acceptance SHALL NOT affect the result in progress.

Reset
REQ-024 While rst is high at a rising edge, the state SHALL become IDLE and busy, done, bout, diff, the counter and the borrow flop SHALL all become 0.
REQ-025 rst SHALL take priority over start.
REQ-026 rst asserted mid-SHIFT SHALL abort the operation with no done pulse.

Structure
REQ-027 A shared package serial_arith_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-028 The per-bit arithmetic SHALL be a combinational sub-module full_subtractor, with ports a, b, bin, diff and bout.
REQ-029 Exactly one full_subtractor instance SHALL exist; no WIDTH-wide parallel subtractor SHALL be inferred.

Verification
REQ-030 Basic: WIDTH=8, val1=100, val2=37, bin=0 -> done at cycle 9 with diff=63, bout=0.
REQ-031 Underflow: val1=5, val2=9, bin=0 -> diff=252, bout=1; also val1=0, val2=0, bin=1 -> diff=255, bout=1.
REQ-032 Equality: val1=255, val2=255, bin=0 -> diff=0, bout=0; also val1=255, val2=254, bin=1 -> diff=0, bout=0.
REQ-033 Busy ignore: a second start in cycle 3 of SHIFT with different operands -> the first result is returned unchanged and only one done pulse occurs.
REQ-034 Reset mid-op: rst in cycle 4 of SHIFT -> next cycle shows busy=0, done=0, diff=0, bout=0; a new start then completes correctly.
REQ-035 Back-to-back: start held high through DONE with new operands 200 - 56 -> second done exactly WIDTH+1 cycles after the first, with diff=144, bout=0.
